// File: rtl/op_result_unpacker.sv
// Splits packed ALU result words into tag/data/zero fields and buffers them in a
// small ready/valid FIFO. It also keeps a saturating count of shift-class results.
module op_result_unpacker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [11:0]             in_word,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_tag,
  output logic [5:0]              out_data,
  output logic                    out_zero,
  output logic [CNT_W-1:0]        shift_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [1:0] tag;
    logic [5:0] data;
    logic       zero;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head_q;
  entry_t          head_next;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   remain;
  logic [LW-1:0]   level_next;
  logic            push;
  logic            pop;
  logic            unused_mid;

  // Bits [9:6] of the packed word carry nothing for this block.
  assign unused_mid = ^in_word[9:6];

  assign in_ready  = (level_q < FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry.tag  = in_word[11:10];
    in_entry.data = in_word[5:0];
    in_entry.zero = (in_word[5:0] == 6'd0);
  end

  // The head is registered so it can hold its last value once the buffer drains.
  // If old entries survive the pop, the new head is read from memory. Otherwise
  // the incoming word becomes the head.
  always_comb begin
    rd_next    = rd_ptr + AW'(pop);
    remain     = level_q - LW'(pop);
    level_next = remain + LW'(push);
    head_next  = head_q;
    if (remain != '0) begin
      head_next = mem[rd_next];
    end else if (push) begin
      head_next = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      head_q    <= '0;
      shift_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      level_q <= level_next;
      head_q  <= head_next;
      if (push && (in_word[11:10] == 2'b01) && (shift_cnt != '1)) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  assign out_tag  = head_q.tag;
  assign out_data = head_q.data;
  assign out_zero = head_q.zero;
  assign level    = level_q;

endmodule

// File: tb/tb_op_result_unpacker.sv
// Self-checking bench for op_result_unpacker: directed vector table, hand sequences,
// and random traffic checked against a queue-based reference model.
module tb_op_result_unpacker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic [11:0]             in_word = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [1:0]              out_tag;
  logic [5:0]              out_data;
  logic                    out_zero;
  logic [CNT_W-1:0]        shift_cnt;
  logic [$clog2(DEPTH):0]  level;

  op_result_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data), .out_zero(out_zero),
    .shift_cnt(shift_cnt), .level(level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: the buffered {tag,data} pairs, the last head shown, and a shift count.
  logic [7:0] mq[$];
  logic [1:0] m_tag = '0;
  logic [5:0] m_data = '0;
  logic       m_zero = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [11:0] wd(input logic [1:0] tag, input logic [5:0] data);
    logic [3:0] mid;
    mid = 4'($urandom);
    return {tag, mid, data};
  endfunction

  task automatic model_check(input string tagname);
    chk({tagname, "_valid"}, int'(out_valid), int'(mq.size() > 0));
    chk({tagname, "_ready"}, int'(in_ready), int'(mq.size() < DEPTH));
    chk({tagname, "_level"}, int'(level), mq.size());
    chk({tagname, "_cnt"}, int'(shift_cnt), m_cnt);
    chk({tagname, "_tag"}, int'(out_tag), int'(m_tag));
    chk({tagname, "_data"}, int'(out_data), int'(m_data));
    chk({tagname, "_zero"}, int'(out_zero), int'(m_zero));
  endtask

  // One clock: drive inputs, update the model at the edge, then check just after the edge.
  task automatic cycle(input logic rst, input logic v, input logic [11:0] w, input logic r);
    bit do_push, do_pop;
    reset = rst; in_valid = v; in_word = w; out_ready = r;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = r && (mq.size() > 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0;
      {m_tag, m_data, m_zero} = '0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({w[11:10], w[5:0]});
        if (w[11:10] == 2'b01 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (mq.size() > 0) begin
        m_tag  = mq[0][7:6];
        m_data = mq[0][5:0];
        m_zero = (mq[0][5:0] == 6'd0);
      end
    end
    #1;
    model_check("mdl");
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [11:0] w;
    logic       r;
    logic       ev;
    logic       er;
    int         elvl;
    logic [1:0] etag;
    logic [5:0] edata;
    logic       ez;
    int         ecnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic v, input logic [11:0] w, input logic r,
                              input logic ev, input logic er, input int elvl, input logic [1:0] etag,
                              input logic [5:0] edata, input logic ez, input int ecnt);
    vec_t t;
    t.rst = rst; t.v = v; t.w = w; t.r = r;
    t.ev = ev; t.er = er; t.elvl = elvl; t.etag = etag; t.edata = edata; t.ez = ez; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // Reset, then push a single shift word into an empty buffer.
    tbl.push_back(mk(1, 0, 12'h000, 0,  0, 1, 0, 2'd0, 6'd0,  0, 0));
    tbl.push_back(mk(0, 1, 12'b01_1010_001100, 0,  1, 1, 1, 2'd1, 6'd12, 0, 1));
    // Fill with four words, refuse a fifth, then drain them in order.
    tbl.push_back(mk(1, 0, 12'h000, 0,  0, 1, 0, 2'd0, 6'd0,  0, 0));
    tbl.push_back(mk(0, 1, wd(2'd0, 6'd1), 0,  1, 1, 1, 2'd0, 6'd1, 0, 0));
    tbl.push_back(mk(0, 1, wd(2'd1, 6'd2), 0,  1, 1, 2, 2'd0, 6'd1, 0, 1));
    tbl.push_back(mk(0, 1, wd(2'd2, 6'd3), 0,  1, 1, 3, 2'd0, 6'd1, 0, 1));
    tbl.push_back(mk(0, 1, wd(2'd3, 6'd4), 0,  1, 0, 4, 2'd0, 6'd1, 0, 1));
    tbl.push_back(mk(0, 1, wd(2'd1, 6'd9), 0,  1, 0, 4, 2'd0, 6'd1, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1,  1, 1, 3, 2'd1, 6'd2, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1,  1, 1, 2, 2'd2, 6'd3, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1,  1, 1, 1, 2'd3, 6'd4, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1,  0, 1, 0, 2'd3, 6'd4, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1,  0, 1, 0, 2'd3, 6'd4, 0, 1));
    // A zero result raises out_zero.
    tbl.push_back(mk(0, 1, 12'b01_1111_000000, 0,  1, 1, 1, 2'd1, 6'd0, 1, 2));
  end

  initial begin
    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].w, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].er));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].elvl);
      chk($sformatf("tbl%0d_tag", i), int'(out_tag), int'(tbl[i].etag));
      chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].edata));
      chk($sformatf("tbl%0d_zero", i), int'(out_zero), int'(tbl[i].ez));
      chk($sformatf("tbl%0d_cnt", i), int'(shift_cnt), tbl[i].ecnt);
    end

    // Unknown don't-care bits must not reach any output.
    cycle(0, 1, {2'b10, 4'bxxxx, 6'd5}, 0);
    chk("no_x_out", int'($isunknown({out_valid, in_ready, out_tag, out_data, out_zero, shift_cnt, level})), 0);

    // When full, a pop in the same cycle still blocks the push.
    cycle(1, 0, 12'h000, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, wd(2'(i), 6'(i + 10)), 0);
    cycle(0, 1, wd(2'd1, 6'd33), 1);
    chk("full_pop_level", int'(level), DEPTH - 1);
    chk("full_pop_head", int'(out_data), 11);

    // Steady state: two entries stay buffered while words stream through.
    cycle(1, 0, 12'h000, 0);
    cycle(0, 1, wd(2'd2, 6'd40), 0);
    cycle(0, 1, wd(2'd3, 6'd41), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, wd(2'($urandom), 6'($urandom)), 1);
      chk($sformatf("stream%0d_level", i), int'(level), 2);
    end

    // The shift counter saturates at 255.
    cycle(1, 0, 12'h000, 0);
    for (int i = 0; i < 260; i++) cycle(0, 1, wd(2'd1, 6'($urandom)), 1);
    chk("sat_cnt", int'(shift_cnt), 255);
    cycle(0, 1, wd(2'd1, 6'd1), 1);
    chk("sat_hold", int'(shift_cnt), 255);

    // Reset wins over a simultaneous push and pop, and buffered entries are lost.
    cycle(1, 0, 12'h000, 0);
    cycle(0, 1, wd(2'd1, 6'd21), 0);
    cycle(0, 1, wd(2'd2, 6'd22), 0);
    cycle(0, 1, wd(2'd3, 6'd23), 0);
    chk("pre_rst_level", int'(level), 3);
    cycle(1, 1, wd(2'd1, 6'd24), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_cnt", int'(shift_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 12'h000, 1);
      chk($sformatf("rst_flush%0d", i), int'({out_valid, out_data}), 0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
            12'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/op_result_unpacker.md
OP_RESULT_UNPACKER -- requirements
Module: op_result_unpacker

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of result-buffer entries; legal values are powers of two, 2 to 16.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the shift-operation counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL indicate that in_word holds a packed ALU result word.
REQ-006 Port in_word, input, 12 bits, SHALL carry the packed word: [11:10] op tag, [9:6] don't-care, [5:0] result.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the block can accept a word this cycle.
REQ-008 Port out_valid, output, 1 bit, SHALL indicate that out_tag, out_data and out_zero are valid.
REQ-009 Port out_ready, input, 1 bit, SHALL indicate that the consumer accepts the presented entry.
REQ-010 Port out_tag, output, 2 bits, SHALL present the op tag of the head entry.
REQ-011 Port out_data, output, 6 bits, SHALL present the 6-bit result of the head entry.
REQ-012 Port out_zero, output, 1 bit, SHALL be 1 when out_data of the head entry is 6'b000000.
REQ-013 Port shift_cnt, output, CNT_W bits, SHALL count accepted words whose tag is 2'b01 (shift class).
REQ-014 Port level, output, log2(DEPTH)+1 bits, SHALL report the current buffer occupancy.

Function
REQ-015 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be 1 exactly when level < DEPTH; it SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL be 1 exactly when level > 0.
REQ-019 On a push, the block SHALL store in_word[11:10] and in_word[5:0]; bits [9:6] SHALL be discarded and SHALL NOT affect any output, including when they are X.
REQ-020 out_zero SHALL be computed from the stored 6-bit result at write time and stored with the entry.
REQ-021 Latency SHALL be one cycle: a word pushed into an empty buffer at edge N SHALL appear on the outputs with out_valid=1 after edge N.
REQ-022 Entries SHALL be delivered in strict push order, with no loss or duplication.
REQ-023 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Write and read pointers SHALL wrap modulo DEPTH.
REQ-025 Simultaneous push and pop at 0 < level < DEPTH SHALL leave level unchanged.
REQ-026 When full, in_ready=0, so no push SHALL occur even if a pop happens in the same cycle.
REQ-027 When empty, out_ready=1 SHALL have no effect, and out_tag, out_data and out_zero SHALL hold their last values.
REQ-028 shift_cnt SHALL increment by 1 on each push with tag 2'b01.
REQ-029 shift_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 The block SHALL contain no state machine beyond the pointers, level and counter; all four tag values SHALL be passed through unmodified.

Reset
REQ-031 While reset=1 at a rising edge, the block SHALL clear level, both pointers and shift_cnt to 0.
REQ-032 While reset=1 at a rising edge, out_valid SHALL be 0, in_ready SHALL be 1, and out_tag, out_data and out_zero SHALL be 0 (out_zero=0 because out_valid=0).
REQ-033 Reset SHALL take priority over a simultaneous push or pop.
REQ-034 Entries held in the buffer at reset SHALL be discarded and never delivered.

Verification
REQ-035 Scenario: push 12'b01_xxxx_001100 into an empty buffer with out_ready=0 -> next cycle out_valid=1, out_tag=2'b01, out_data=6'b001100, out_zero=0, shift_cnt=1, level=1.
REQ-036 Scenario: with out_ready=0, push 4 words with tags 00/01/10/11 and data 1/2/3/4 -> in_ready=0 and level=4; a 5th in_valid pulse is not accepted; then out_ready=1 drains 1, 2, 3, 4 in order, and shift_cnt=1.
REQ-037 Scenario: at level=2, hold in_valid=1 and out_ready=1 for 10 cycles -> level stays 2 and the output sequence equals the input sequence delayed by 2 entries.
REQ-038 Scenario: push 12'b01_1111_000000 -> out_data=0 and out_zero=1; bits [9:6] driven X produce no X on any output.
REQ-039 Scenario: with CNT_W=8, push 260 words with tag 01 -> shift_cnt reads 255 and holds.
REQ-040 Scenario: at level=3, assert reset for one cycle together with in_valid=1 and out_ready=1 -> level=0, out_valid=0, in_ready=1, shift_cnt=0, and none of the buffered entries ever appear on the outputs.
